// File: rtl/motor_link_pkg.sv
// Shared types and frame layout for the motor link arbiter.
package motor_link_pkg;

  typedef logic [4:0] motor_cmd_t;

  localparam motor_cmd_t CMD_STOP = 5'd0;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } link_state_t;

  localparam int FRM_MARK = 7;
  localparam int FRM_SRC  = 6;
  localparam int FRM_KA   = 5;

  function automatic logic [7:0] make_frame(input logic src, input logic ka, input motor_cmd_t cmd);
    logic [7:0] f;
    f           = '0;
    f[FRM_MARK] = 1'b1;
    f[FRM_SRC]  = src;
    f[FRM_KA]   = ka;
    f[4:0]      = cmd;
    return f;
  endfunction

endpackage

// File: rtl/motor_link_timer.sv
// Loadable down-counter with a terminal-count (zero) flag; saturates at zero.
module motor_link_timer #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      count_q <= INIT;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero = (count_q == '0);

endmodule

// File: rtl/motor_link_arbiter.sv
// Arbitrates manual/auto motor commands onto one UART byte link with stop priority
// and a minimum inter-frame gap. Optional keepalive resend: define MOTOR_KEEPALIVE_EN.
//
// state | meaning
// IDLE  | link free; arbitrate pending requests each cycle
// SEND  | framed byte presented, waiting for tx_ready
// GAP   | enforced idle time after an accepted byte
module motor_link_arbiter
  import motor_link_pkg::*;
#(
  parameter int unsigned GAP_CYCLES       = 5000,
  parameter int unsigned KEEPALIVE_CYCLES = 5_000_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  motor_cmd_t man_cmd,
  input  logic       man_req,
  output logic       man_gnt,
  input  motor_cmd_t auto_cmd,
  input  logic       auto_req,
  output logic       auto_gnt,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       busy
);

  localparam int unsigned      GAP_W    = $clog2(GAP_CYCLES + 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

  if ((GAP_CYCLES < 1) || (KEEPALIVE_CYCLES < 1)) begin : g_bad_param
    $error("motor_link_arbiter: GAP_CYCLES and KEEPALIVE_CYCLES must be at least 1");
  end

  link_state_t state_q, state_d;
  logic        man_gnt_q, man_gnt_d;
  logic        auto_gnt_q, auto_gnt_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        gap_load;
  logic        gap_zero;
  logic        pick_man;
  logic        pick_auto;

  // A stop from either source pre-empts everything; manual wins ties.
  assign pick_man  = man_req && ((man_cmd == CMD_STOP) || !(auto_req && (auto_cmd == CMD_STOP)));
  assign pick_auto = auto_req && !pick_man;

  motor_link_timer #(
    .WIDTH (GAP_W),
    .INIT  ('0)
  ) u_gap_timer (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .load     (gap_load),
    .load_val (GAP_LOAD),
    .en       (state_q == GAP),
    .zero     (gap_zero)
  );

`ifdef MOTOR_KEEPALIVE_EN
  localparam int unsigned     KA_W    = $clog2(KEEPALIVE_CYCLES + 1);
  localparam logic [KA_W-1:0] KA_LOAD = KA_W'(KEEPALIVE_CYCLES - 1);

  logic ka_zero;

  // Held at its reload value outside IDLE, so every IDLE stretch starts a fresh count.
  motor_link_timer #(
    .WIDTH (KA_W),
    .INIT  (KA_LOAD)
  ) u_ka_timer (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .load     (state_q != IDLE),
    .load_val (KA_LOAD),
    .en       (state_q == IDLE),
    .zero     (ka_zero)
  );
`endif

  always_comb begin
    state_d    = state_q;
    tx_data_d  = tx_data_q;
    man_gnt_d  = 1'b0;
    auto_gnt_d = 1'b0;
    gap_load   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_man) begin
          man_gnt_d = 1'b1;
          tx_data_d = make_frame(1'b0, 1'b0, man_cmd);
          state_d   = SEND;
        end else if (pick_auto) begin
          auto_gnt_d = 1'b1;
          tx_data_d  = make_frame(1'b1, 1'b0, auto_cmd);
          state_d    = SEND;
        end
`ifdef MOTOR_KEEPALIVE_EN
        // The last frame doubles as last_src/last_cmd storage; reset leaves it at zero.
        else if (ka_zero) begin
          tx_data_d = make_frame(tx_data_q[FRM_SRC], 1'b1, tx_data_q[4:0]);
          state_d   = SEND;
        end
`endif
      end
      SEND: begin
        if (tx_ready) begin
          gap_load = 1'b1;
          state_d  = GAP;
        end
      end
      GAP: begin
        if (gap_zero) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= IDLE;
      man_gnt_q  <= 1'b0;
      auto_gnt_q <= 1'b0;
      tx_data_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      man_gnt_q  <= man_gnt_d;
      auto_gnt_q <= auto_gnt_d;
      tx_data_q  <= tx_data_d;
    end
  end

  assign man_gnt  = man_gnt_q;
  assign auto_gnt = auto_gnt_q;
  assign tx_data  = tx_data_q;
  assign tx_valid = (state_q == SEND);
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_motor_link_arbiter.sv
// Scoreboard bench for motor_link_arbiter: timestamp-based link model plus grant/byte queues.
module tb_motor_link_arbiter;
  import motor_link_pkg::*;

  localparam int GAP_C = 8;
  localparam int KA_C  = 100;

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  motor_cmd_t man_cmd, auto_cmd;
  logic       man_req, auto_req, man_gnt, auto_gnt;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, busy;

  always #10 CLOCK_50 = ~CLOCK_50;

  motor_link_arbiter #(
    .GAP_CYCLES       (GAP_C),
    .KEEPALIVE_CYCLES (KA_C)
  ) dut (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .man_cmd  (man_cmd),
    .man_req  (man_req),
    .man_gnt  (man_gnt),
    .auto_cmd (auto_cmd),
    .auto_req (auto_req),
    .auto_gnt (auto_gnt),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction

  typedef struct packed {
    logic       src;
    logic [7:0] frame;
  } gnt_t;

  gnt_t       gq[$];
  logic [7:0] bq[$];
  bit         exp_busy = 1'b0;

  // Reference model: the link is either holding a byte (in_send) or free from edge idle_at on.
  initial begin
    longint     cyc;
    longint     idle_at;
    bit         in_send;
    bit         have;
    logic       src;
    motor_cmd_t c;
    logic [7:0] frame;
`ifdef MOTOR_KEEPALIVE_EN
    logic       last_src;
    motor_cmd_t last_cmd;
    last_src = 1'b0;
    last_cmd = 5'd0;
`endif
    cyc     = 0;
    idle_at = 0;
    in_send = 1'b0;
    forever begin
      @(posedge CLOCK_50);
      if (reset) begin
        in_send = 1'b0;
        idle_at = cyc + 1;
        gq.delete();
        bq.delete();
`ifdef MOTOR_KEEPALIVE_EN
        last_src = 1'b0;
        last_cmd = 5'd0;
`endif
      end else if (in_send) begin
        if (tx_ready) begin
          in_send = 1'b0;
          idle_at = cyc + 1 + GAP_C;
        end
      end else if (cyc >= idle_at) begin
        have = 1'b1;
        src  = 1'b0;
        c    = man_cmd;
        if (man_req && man_cmd == 5'd0) begin
          src = 1'b0; c = man_cmd;
        end else if (auto_req && auto_cmd == 5'd0) begin
          src = 1'b1; c = auto_cmd;
        end else if (man_req) begin
          src = 1'b0; c = man_cmd;
        end else if (auto_req) begin
          src = 1'b1; c = auto_cmd;
        end else begin
          have = 1'b0;
        end
        if (have) begin
          frame = {1'b1, src, 1'b0, c};
          gq.push_back({src, frame});
          bq.push_back(frame);
          in_send = 1'b1;
`ifdef MOTOR_KEEPALIVE_EN
          last_src = src;
          last_cmd = c;
`endif
        end
`ifdef MOTOR_KEEPALIVE_EN
        else if (cyc == idle_at + KA_C - 1) begin
          bq.push_back({1'b1, last_src, 1'b1, last_cmd});
          in_send = 1'b1;
        end
`endif
      end
      exp_busy = in_send || (idle_at > cyc + 1);
      cyc++;
    end
  end

  // Monitor: grants must appear exactly one cycle after the model issued them.
  initial begin
    gnt_t       e;
    logic [7:0] b;
    forever begin
      @(negedge CLOCK_50);
      if (gq.size() > 0) begin
        e = gq.pop_front();
        chk("grant", 32'({man_gnt, auto_gnt, tx_valid, tx_data}),
            32'({~e.src, e.src, 1'b1, e.frame}));
      end else if (man_gnt || auto_gnt) begin
        chk("spurious_grant", 32'({man_gnt, auto_gnt}), 32'(0));
      end
      if (tx_valid && tx_ready && !reset) begin
        if (bq.size() > 0) begin
          b = bq.pop_front();
          chk("byte", 32'(tx_data), 32'(b));
        end else begin
          chk("spurious_byte", 32'({1'b1, tx_data}), 32'(0));
        end
      end
      chk("busy", 32'(busy), 32'(exp_busy));
    end
  end

  task automatic step();
    @(posedge CLOCK_50);
    #1;
    if (man_gnt) man_req = 1'b0;
    if (auto_gnt) auto_req = 1'b0;
  endtask

  function automatic motor_cmd_t rand_cmd();
    int unsigned r;
    r = $urandom_range(0, 5);
    if (r == 0) return 5'd0;
    return motor_cmd_t'(5'd1 << (r - 1));
  endfunction

  initial begin
    int t;
    reset    = 1'b1;
    man_req  = 1'b0;
    auto_req = 1'b0;
    man_cmd  = 5'd0;
    auto_cmd = 5'd0;
    tx_ready = 1'b1;
    repeat (3) step();
    chk("reset_values", 32'({man_gnt, auto_gnt, tx_valid, tx_data, busy}), 32'(0));
    reset = 1'b0;
    step();

    // single manual request
    man_cmd = 5'b00010; man_req = 1'b1;
    step();
    chk("single_data", 32'(tx_data), 32'h82);
    repeat (9) step();
    chk("single_busy_low", 32'(busy), 32'(0));
    repeat (3) step();

    // contention: manual first, auto GAP+2 cycles later
    man_cmd = 5'b00100; man_req = 1'b1;
    auto_cmd = 5'b01000; auto_req = 1'b1;
    step();
    chk("contention_first", 32'({man_gnt, tx_data}), 32'({1'b1, 8'h84}));
    t = 0;
    while (!auto_gnt && t < 30) begin
      step();
      t++;
    end
    chk("contention_spacing", 32'(t), 32'(GAP_C + 2));
    repeat (12) step();

    // stop priority: auto stop beats manual non-stop
    man_cmd = 5'b00010; man_req = 1'b1;
    auto_cmd = 5'd0; auto_req = 1'b1;
    step();
    chk("stop_priority", 32'({auto_gnt, man_gnt, tx_data}), 32'({2'b10, 8'hC0}));
    repeat (25) step();

    // backpressure
    tx_ready = 1'b0;
    man_cmd = 5'b00001; man_req = 1'b1;
    step();
    repeat (20) begin
      step();
      chk("bp_hold", 32'({tx_valid, tx_data}), 32'({1'b1, 8'h81}));
    end
    tx_ready = 1'b1;
    step();
    chk("bp_release", 32'(tx_valid), 32'(0));
    repeat (12) step();

    // reset while a byte is in flight
    tx_ready = 1'b0;
    auto_cmd = 5'b10000; auto_req = 1'b1;
    step();
    chk("rst_pre_valid", 32'(tx_valid), 32'(1));
    reset = 1'b1;
    step();
    chk("rst_mid_send", 32'({tx_valid, tx_data, busy, man_gnt, auto_gnt}), 32'(0));
    reset = 1'b0;
    tx_ready = 1'b1;

    // long idle: silent link, or a keepalive frame when enabled
    repeat (KA_C + 20) step();

    // randomized traffic
    repeat (3000) begin
      step();
      tx_ready = ($urandom_range(0, 3) != 0);
      if (!man_req && $urandom_range(0, 5) == 0) begin
        man_cmd = rand_cmd(); man_req = 1'b1;
      end
      if (!auto_req && $urandom_range(0, 5) == 0) begin
        auto_cmd = rand_cmd(); auto_req = 1'b1;
      end
    end

    tx_ready = 1'b1;
    t = 0;
    while ((man_req || auto_req || busy) && t < 200) begin
      step();
      t++;
    end
    chk("drain_bound", 32'(t < 200), 32'(1));
    repeat (3) step();
    chk("queues_empty", 32'(gq.size() + bq.size()), 32'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
